prf_multiport: RTL and testbench

PRF_MULTIPORT -- requirements
Module: prf_multiport

---
 rtl/prf_pkg.sv | 14 +
 rtl/prf_ready_table.sv | 71 +++++++
 rtl/prf_multiport.sv | 100 ++++++++++
 tb/tb_prf_multiport.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prf_pkg.sv
// rtl/prf_pkg.sv - shared sizing defaults and index type for the physical register file
package prf_pkg;

    localparam int PRF_NUM_PREG = 64;
    localparam int PRF_DATA_W   = 32;
    localparam int PRF_NUM_RP   = 12;
    localparam int PRF_NUM_WP   = 4;
    localparam int PRF_NUM_AP   = 4;
    localparam int PRF_IDX_W    = $clog2(PRF_NUM_PREG);

    // Physical register index at the default register count
    typedef logic [PRF_IDX_W-1:0] preg_idx_t;

endpackage

// File: rtl/prf_ready_table.sv
// rtl/prf_ready_table.sv - per-register ready bits: alloc clear, write-back set, flush load, read ports
// Optional feature macro: PRF_WB_BYPASS_EN (same-cycle write-back forwarding of the ready bit)
module prf_ready_table
    import prf_pkg::*;
#(
    parameter int NUM_PREG = PRF_NUM_PREG,
    parameter int NUM_RP   = PRF_NUM_RP,
    parameter int NUM_WP   = PRF_NUM_WP,
    parameter int NUM_AP   = PRF_NUM_AP,
    localparam int IDX_W   = $clog2(NUM_PREG)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_WP-1:0]             i_wb_valid,
    input  logic [NUM_WP-1:0][IDX_W-1:0]  i_wb_idx,
    input  logic [NUM_AP-1:0]             i_alloc_valid,
    input  logic [NUM_AP-1:0][IDX_W-1:0]  i_alloc_idx,
    input  logic                          i_flush,
    input  logic [NUM_PREG-1:0]           i_flush_mask,
    input  logic [NUM_RP-1:0][IDX_W-1:0]  i_rd_idx,
    output logic [NUM_RP-1:0]             o_rd_ready
);

    logic [NUM_PREG-1:0] r_ready;
    logic [NUM_PREG-1:0] w_ready_next;

    // Next ready table: wb sets, alloc clears (wins over wb), flush overrides both; preg 0 always ready
    always_comb begin
        w_ready_next = r_ready;
        for (int j = 0; j < NUM_WP; j++) begin
            if (i_wb_valid[j]) begin
                w_ready_next[i_wb_idx[j]] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_AP; k++) begin
            if (i_alloc_valid[k]) begin
                w_ready_next[i_alloc_idx[k]] = 1'b0;
            end
        end
        if (i_flush) begin
            w_ready_next = i_flush_mask;
        end
        w_ready_next[0] = 1'b1;
    end

    // Ready table register; reset marks every register ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready <= '1;
        end else begin
            r_ready <= w_ready_next;
        end
    end

    // Read ports see the table before this cycle's updates, except a forwarded write-back
    always_comb begin
        o_rd_ready = '0;
        for (int p = 0; p < NUM_RP; p++) begin
            o_rd_ready[p] = r_ready[i_rd_idx[p]];
`ifdef PRF_WB_BYPASS_EN
            for (int j = 0; j < NUM_WP; j++) begin
                if (i_wb_valid[j] && (i_wb_idx[j] == i_rd_idx[p]) && (i_rd_idx[p] != '0)) begin
                    // Post-update bit so a same-cycle alloc or flush still reads as not-ready
                    o_rd_ready[p] = w_ready_next[i_rd_idx[p]];
                end
            end
`endif
        end
    end

endmodule

// File: rtl/prf_multiport.sv
// rtl/prf_multiport.sv - multiport physical register file with ready bits; optional macro PRF_WB_BYPASS_EN
module prf_multiport
    import prf_pkg::*;
#(
    parameter int NUM_PREG = PRF_NUM_PREG,
    parameter int DATA_W   = PRF_DATA_W,
    parameter int NUM_RP   = PRF_NUM_RP,
    parameter int NUM_WP   = PRF_NUM_WP,
    parameter int NUM_AP   = PRF_NUM_AP,
    localparam int IDX_W   = $clog2(NUM_PREG)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_RP-1:0]             i_rd_en,
    input  logic [NUM_RP-1:0][IDX_W-1:0]  i_rd_idx,
    output logic [NUM_RP-1:0][DATA_W-1:0] o_rd_data,
    output logic [NUM_RP-1:0]             o_rd_ready,
    input  logic [NUM_WP-1:0]             i_wb_valid,
    input  logic [NUM_WP-1:0][IDX_W-1:0]  i_wb_idx,
    input  logic [NUM_WP-1:0][DATA_W-1:0] i_wb_data,
    input  logic [NUM_AP-1:0]             i_alloc_valid,
    input  logic [NUM_AP-1:0][IDX_W-1:0]  i_alloc_idx,
    input  logic                          i_flush,
    input  logic [NUM_PREG-1:0]           i_flush_ready_mask,
    input  logic [IDX_W-1:0]              i_dbg_idx,
    output logic [DATA_W-1:0]             o_dbg_data
);

    logic [DATA_W-1:0]             r_data [NUM_PREG];
    logic [NUM_RP-1:0][DATA_W-1:0] r_rd_data;
    logic [NUM_RP-1:0]             r_rd_ready;
    logic [NUM_RP-1:0][DATA_W-1:0] w_rd_data;
    logic [NUM_RP-1:0]             w_rd_ready;

    prf_ready_table #(
        .NUM_PREG (NUM_PREG),
        .NUM_RP   (NUM_RP),
        .NUM_WP   (NUM_WP),
        .NUM_AP   (NUM_AP)
    ) u_ready_table (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_wb_valid    (i_wb_valid),
        .i_wb_idx      (i_wb_idx),
        .i_alloc_valid (i_alloc_valid),
        .i_alloc_idx   (i_alloc_idx),
        .i_flush       (i_flush),
        .i_flush_mask  (i_flush_ready_mask),
        .i_rd_idx      (i_rd_idx),
        .o_rd_ready    (w_rd_ready)
    );

    // Write-back into storage; ascending port loop lets the highest port win, preg 0 never written
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WP; j++) begin
                if (i_wb_valid[j] && (i_wb_idx[j] != '0)) begin
                    r_data[i_wb_idx[j]] <= i_wb_data[j];
                end
            end
        end
    end

    // Read data selection: stored value, optionally overridden by the highest matching write-back
    always_comb begin
        w_rd_data = '0;
        for (int p = 0; p < NUM_RP; p++) begin
            w_rd_data[p] = (i_rd_idx[p] == '0) ? '0 : r_data[i_rd_idx[p]];
`ifdef PRF_WB_BYPASS_EN
            for (int j = 0; j < NUM_WP; j++) begin
                if (i_wb_valid[j] && (i_wb_idx[j] == i_rd_idx[p]) && (i_rd_idx[p] != '0)) begin
                    w_rd_data[p] = i_wb_data[j];
                end
            end
`endif
        end
    end

    // Registered read results; an idle port returns zero data and not-ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_ready <= '0;
        end else begin
            for (int p = 0; p < NUM_RP; p++) begin
                r_rd_data[p]  <= i_rd_en[p] ? w_rd_data[p] : '0;
                r_rd_ready[p] <= i_rd_en[p] & w_rd_ready[p];
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_ready = r_rd_ready;
    assign o_dbg_data = (i_dbg_idx == '0) ? '0 : r_data[i_dbg_idx];

endmodule

// File: tb/tb_prf_multiport.sv
// tb/tb_prf_multiport.sv - directed vector bench for prf_multiport
module tb_prf_multiport;
    import prf_pkg::*;

`ifdef PRF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [11:0]            rd_en;
    logic [11:0][5:0]       rd_idx;
    logic [11:0][31:0]      rd_data;
    logic [11:0]            rd_ready;
    logic [3:0]             wb_valid;
    logic [3:0][5:0]        wb_idx;
    logic [3:0][31:0]       wb_data;
    logic [3:0]             alloc_valid;
    logic [3:0][5:0]        alloc_idx;
    logic                   flush;
    logic [63:0]            flush_mask;
    logic [5:0]             dbg_idx;
    logic [31:0]            dbg_data;

    int n_vec = 0;
    int n_err = 0;

    prf_multiport dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_rd_en            (rd_en),
        .i_rd_idx           (rd_idx),
        .o_rd_data          (rd_data),
        .o_rd_ready         (rd_ready),
        .i_wb_valid         (wb_valid),
        .i_wb_idx           (wb_idx),
        .i_wb_data          (wb_data),
        .i_alloc_valid      (alloc_valid),
        .i_alloc_idx        (alloc_idx),
        .i_flush            (flush),
        .i_flush_ready_mask (flush_mask),
        .i_dbg_idx          (dbg_idx),
        .o_dbg_data         (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          wp0;
        preg_idx_t   wi0;
        logic [31:0] wd0;
        int          wp1;
        preg_idx_t   wi1;
        logic [31:0] wd1;
        logic        ae;
        preg_idx_t   ai;
        logic        re;
        int          rp;
        preg_idx_t   ri;
        logic [31:0] ed;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int wp0, int wi0, logic [31:0] wd0, int wp1, int wi1, logic [31:0] wd1,
                                logic ae, int ai, logic re, int rp, int ri, logic [31:0] ed, logic er);
        vec_t v;
        v.wp0 = wp0; v.wi0 = preg_idx_t'(wi0); v.wd0 = wd0;
        v.wp1 = wp1; v.wi1 = preg_idx_t'(wi1); v.wd1 = wd1;
        v.ae = ae; v.ai = preg_idx_t'(ai);
        v.re = re; v.rp = rp; v.ri = preg_idx_t'(ri);
        v.ed = ed; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] ad, input logic ar,
                       input logic [31:0] ed, input logic er);
        n_vec++;
        if (ad !== ed || ar !== er) begin
            n_err++;
            $display("FAIL %s: got data=%h ready=%b, expected data=%h ready=%b", nm, ad, ar, ed, er);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_idx = '0;
        wb_valid = '0; wb_idx = '0; wb_data = '0;
        alloc_valid = '0; alloc_idx = '0;
        flush = 1'b0; flush_mask = '0;
    endtask

    task automatic apply(input vec_t v, input int n);
        @(negedge clk);
        idle();
        if (v.wp0 >= 0) begin wb_valid[v.wp0] = 1'b1; wb_idx[v.wp0] = v.wi0; wb_data[v.wp0] = v.wd0; end
        if (v.wp1 >= 0) begin wb_valid[v.wp1] = 1'b1; wb_idx[v.wp1] = v.wi1; wb_data[v.wp1] = v.wd1; end
        alloc_valid[1] = v.ae; alloc_idx[1] = v.ai;
        rd_en[v.rp] = v.re; rd_idx[v.rp] = v.ri;
        @(posedge clk); #1;
        chk($sformatf("vec%0d", n), rd_data[v.rp], rd_ready[v.rp], v.ed, v.er);
    endtask

    initial begin
        idle();
        dbg_idx = 6'd0;
        rst_n = 1'b0;
        #12;
        chk("reset_rd_port0", rd_data[0], rd_ready[0], 32'h0, 1'b0);
        chk("reset_rd_ready_all", 32'(rd_ready), 1'b0, 32'h0, 1'b0);
        dbg_idx = 6'd5; #1;
        chk("reset_dbg5", dbg_data, 1'b0, 32'h0, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        //       wp0 wi0 wd0            wp1 wi1 wd1    ae ai  re rp ri   exp data                 exp rdy
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 0, 5,   32'h0,                   1'b1));
        vecs.push_back(mk( 2, 9, 32'hDEADBEEF, -1, 0, 0,     0, 0,  0, 0, 0,   32'h0,                   1'b0));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 1, 9,   32'hDEADBEEF,            1'b1));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  0, 1, 9,   32'h0,                   1'b0));
        vecs.push_back(mk( 0, 12, 32'h11,      -1, 0, 0,     0, 0,  1, 3, 12,  BYP ? 32'h11 : 32'h0,    1'b1));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 11, 12, 32'h11,                  1'b1));
        vecs.push_back(mk( 0, 7, 32'hA,         3, 7, 32'hB, 0, 0,  0, 2, 0,   32'h0,                   1'b0));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 2, 7,   32'hB,                   1'b1));
        vecs.push_back(mk( 1, 0, 32'h55,       -1, 0, 0,     0, 0,  1, 4, 0,   32'h0,                   1'b1));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 4, 0,   32'h0,                   1'b1));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     1, 20, 1, 5, 20,  32'h0,                   1'b1));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 5, 20,  32'h0,                   1'b0));
        vecs.push_back(mk( 2, 20, 32'h1234,    -1, 0, 0,     1, 20, 1, 6, 20,  BYP ? 32'h1234 : 32'h0,  1'b0));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 6, 20,  32'h1234,                1'b0));
        vecs.push_back(mk( 3, 20, 32'h5678,    -1, 0, 0,     0, 0,  1, 7, 20,  BYP ? 32'h5678 : 32'h1234, BYP));
        vecs.push_back(mk(-1, 0, 0,            -1, 0, 0,     0, 0,  1, 7, 20,  32'h5678,                1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Combinational debug read of committed values
        @(negedge clk); idle();
        dbg_idx = 6'd9; #1;
        chk("dbg_idx9", dbg_data, 1'b0, 32'hDEADBEEF, 1'b0);
        dbg_idx = 6'd0; #1;
        chk("dbg_idx0", dbg_data, 1'b0, 32'h0, 1'b0);
        dbg_idx = 6'd7; #1;
        chk("dbg_idx7", dbg_data, 1'b0, 32'hB, 1'b0);

        // Flush: mask loads the table, same-cycle wb ready and alloc ignored, wb data kept
        @(negedge clk); idle();
        flush = 1'b1; flush_mask = 64'hFFFF_FFFF_0000_0000;
        wb_valid[0] = 1'b1; wb_idx[0] = 6'd4; wb_data[0] = 32'h99;
        alloc_valid[2] = 1'b1; alloc_idx[2] = 6'd40;
        @(negedge clk); idle();
        rd_en[3:0] = 4'hF;
        rd_idx[0] = 6'd3; rd_idx[1] = 6'd0; rd_idx[2] = 6'd40; rd_idx[3] = 6'd4;
        @(posedge clk); #1;
        chk("flush_idx3", rd_data[0], rd_ready[0], 32'h0, 1'b0);
        chk("flush_idx0", rd_data[1], rd_ready[1], 32'h0, 1'b1);
        chk("flush_idx40", rd_data[2], rd_ready[2], 32'h0, 1'b1);
        chk("flush_idx4_wb", rd_data[3], rd_ready[3], 32'h99, 1'b0);

        // Reset mid-read: in-flight read abandoned, storage cleared, ready restored
        @(negedge clk); idle();
        rd_en[0] = 1'b1; rd_idx[0] = 6'd9;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_port0", rd_data[0], rd_ready[0], 32'h0, 1'b0);
        dbg_idx = 6'd9; #1;
        chk("rst_mid_dbg9", dbg_data, 1'b0, 32'h0, 1'b0);
        @(negedge clk); idle(); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_first", rd_data[0], rd_ready[0], 32'h0, 1'b0);
        @(negedge clk); idle();
        rd_en[0] = 1'b1; rd_idx[0] = 6'd20;
        @(posedge clk); #1;
        chk("rst_release_idx20", rd_data[0], rd_ready[0], 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
